mem_load_unit: RTL and testbench

Load-side data-memory client for the MEM stage, the reader counterpart to the store path. It accepts one load per request from the EX/MEM register, checks alignment, and issues a word-aligned read on the data bus with a request/acknowledge handshake. It then extracts and sign- or zero-extends the byte, halfword or word and returns the result with the destination register for write-back. It stalls the pipeline for the whole transaction and reports misaligned-load and access-fault exceptions.

---
 rtl/riscv_types.sv | 31 +++
 rtl/load_align_ext.sv | 27 ++
 rtl/mem_load_unit.sv | 156 +++++++++++++++
 tb/tb_mem_load_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_types.sv
// Shared types for the load path: load-width encodings and the load-unit
// FSM states. The atomic unit reuses load_t through load_align_ext.
package riscv_types;

    typedef enum logic [2:0] {
        LOAD_BYTE   = 3'b000,
        LOAD_HALF   = 3'b001,
        LOAD_WORD   = 3'b010,
        LOAD_BYTE_U = 3'b100,
        LOAD_HALF_U = 3'b101
    } load_t;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_BUSY,
        LD_DONE,
        LD_DRAIN
    } ld_state_t;

    // True when the access cannot be served by one word-aligned read.
    function automatic logic load_is_misaligned(input logic [2:0] fun3, input logic [1:0] lane);
        logic mis;
        case (fun3)
            LOAD_BYTE, LOAD_BYTE_U: mis = 1'b0;
            LOAD_HALF, LOAD_HALF_U: mis = lane[0];
            default:                mis = |lane;   // LW and the unused encodings
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Lane select and sign/zero extension of a load result from a bus word.
module load_align_ext
    import riscv_types::*;
(
    input  logic [2:0]  fun3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword, then extend according to the load type.
    always_comb begin
        byte_sel = word[8*lane +: 8];
        half_sel = word[16*lane[1] +: 16];
        case (fun3)
            LOAD_BYTE:   result = {{24{byte_sel[7]}}, byte_sel};
            LOAD_BYTE_U: result = {24'h0, byte_sel};
            LOAD_HALF:   result = {{16{half_sel[15]}}, half_sel};
            LOAD_HALF_U: result = {16'h0, half_sel};
            default:     result = word;   // 011/110/111 behave as LW
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load client: alignment check, word read with req/ack handshake,
// extraction of the loaded value and misaligned/access-fault reporting.
//
// state    | meaning
// LD_IDLE  | no load in flight; accepts a request
// LD_BUSY  | bus read outstanding, result wanted
// LD_DONE  | result valid on data_o/rd_o for one cycle; accepts a request
// LD_DRAIN | load flushed, waiting for the ack so the request can drop
module mem_load_unit
    import riscv_types::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [2:0]  fun3_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    input  logic        rd_ack_i,
    input  logic [31:0] rd_data_i,
    input  logic        rd_err_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] data_o,
    output logic [4:0]  rd_o,
    output logic        load_misaligned_o,
    output logic        access_fault_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);
    // Last BUSY/DRAIN cycle before giving up: counter value seen in that cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);

    ld_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_step;
    logic [31:0]      addr_q;
    logic [2:0]       fun3_q;
    logic [4:0]       rd_q;
    logic             accept, misal_d, fault_d, complete, tmo_hit;
    logic [31:0]      ext_data;

    load_align_ext u_align (
        .fun3   (fun3_q),
        .lane   (addr_q[1:0]),
        .word   (rd_data_i),
        .result (ext_data)
    );

    assign cnt_step = (cnt_q == TMO_MAX) ? cnt_q : cnt_q + 1'b1;
    assign tmo_hit  = TMO_EN && (cnt_q >= TMO_LAST);

    // Next-state, timeout counter and event decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        misal_d  = 1'b0;
        fault_d  = 1'b0;
        complete = 1'b0;
        stall_o  = 1'b0;
        case (state_q)
            LD_IDLE, LD_DONE: begin
                state_d = LD_IDLE;
                if (req_i && !flush_i) begin
                    accept = 1'b1;
                    if (load_is_misaligned(fun3_i, addr_i[1:0])) begin
                        misal_d = 1'b1;
                    end else begin
                        state_d = LD_BUSY;
                        cnt_d   = '0;
                        stall_o = 1'b1;
                    end
                end
            end
            LD_BUSY: begin
                stall_o = 1'b1;
                if (rd_ack_i) begin
                    state_d = LD_IDLE;
                    if (!flush_i) begin
                        if (rd_err_i) begin
                            fault_d = 1'b1;
                        end else begin
                            complete = 1'b1;
                            state_d  = LD_DONE;
                        end
                    end
                end else if (flush_i) begin
                    state_d = LD_DRAIN;
                    cnt_d   = TMO_EN ? cnt_step : cnt_q;
                end else if (tmo_hit) begin
                    state_d = LD_IDLE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = TMO_EN ? cnt_step : cnt_q;
                end
            end
            LD_DRAIN: begin
                stall_o = 1'b1;
                // A flushed load never reports anything, even on timeout.
                if (rd_ack_i || tmo_hit) begin
                    state_d = LD_IDLE;
                end else begin
                    cnt_d = TMO_EN ? cnt_step : cnt_q;
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    // State, counter and captured request fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LD_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            fun3_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= addr_i;
                fun3_q <= fun3_i;
                rd_q   <= rd_i;
            end
        end
    end

    // Registered result and one-cycle exception pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_o            <= '0;
            rd_o              <= '0;
            load_misaligned_o <= 1'b0;
            access_fault_o    <= 1'b0;
        end else begin
            if (complete) begin
                data_o <= ext_data;
                rd_o   <= rd_q;
            end
            load_misaligned_o <= misal_d;
            access_fault_o    <= fault_d;
        end
    end

    assign rd_req_o  = (state_q == LD_BUSY) || (state_q == LD_DRAIN);
    assign rd_addr_o = {addr_q[31:2], 2'b00};
    assign done_o    = (state_q == LD_DONE);

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: a vector table of single loads plus
// hand-written sequences for faults, flush, reset and back-to-back loads.
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_i;
    logic [31:0] addr_i;
    logic [2:0]  fun3_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        rd_req_o;
    logic [31:0] rd_addr_o;
    logic        rd_ack_i;
    logic [31:0] rd_data_i;
    logic        rd_err_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] data_o;
    logic [4:0]  rd_o;
    logic        load_misaligned_o;
    logic        access_fault_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_load_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_i             (req_i),
        .addr_i            (addr_i),
        .fun3_i            (fun3_i),
        .rd_i              (rd_i),
        .flush_i           (flush_i),
        .rd_req_o          (rd_req_o),
        .rd_addr_o         (rd_addr_o),
        .rd_ack_i          (rd_ack_i),
        .rd_data_i         (rd_data_i),
        .rd_err_i          (rd_err_i),
        .stall_o           (stall_o),
        .done_o            (done_o),
        .data_o            (data_o),
        .rd_o              (rd_o),
        .load_misaligned_o (load_misaligned_o),
        .access_fault_o    (access_fault_o)
    );

    typedef struct {
        logic [2:0]  fun3;
        logic [31:0] addr;
        logic [31:0] word;
        int          waits;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Start a new cycle: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample outputs on the falling edge of the current cycle.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_i = 0; flush_i = 0; rd_ack_i = 0; rd_err_i = 0; rd_data_i = 32'h0;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [4:0] r);
        idle_inputs();
        req_i = 1; fun3_i = f; addr_i = a; rd_i = r;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        tick();
        issue(v.fun3, v.addr, v.rd);
        mid();
        chk($sformatf("v%0d stall_accept", i), {31'b0, stall_o}, 32'd1);
        chk($sformatf("v%0d no_req_c0", i), {31'b0, rd_req_o}, 32'd0);
        for (int c = 0; c <= v.waits; c++) begin
            tick();
            idle_inputs();
            if (c == v.waits) begin
                rd_ack_i = 1; rd_data_i = v.word;
            end
            mid();
            chk($sformatf("v%0d rd_req_c%0d", i, c + 1), {31'b0, rd_req_o}, 32'd1);
            chk($sformatf("v%0d rd_addr_c%0d", i, c + 1), rd_addr_o, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d stall_c%0d", i, c + 1), {31'b0, stall_o}, 32'd1);
            chk($sformatf("v%0d early_done_c%0d", i, c + 1), {31'b0, done_o}, 32'd0);
        end
        tick();
        idle_inputs();
        mid();
        chk($sformatf("v%0d done", i), {31'b0, done_o}, 32'd1);
        chk($sformatf("v%0d data", i), data_o, v.exp);
        chk($sformatf("v%0d rd", i), {27'b0, rd_o}, {27'b0, v.rd});
        chk($sformatf("v%0d stall_done", i), {31'b0, stall_o}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{3'b000, 32'h0000_1003, 32'h80FF_FF7F, 0, 5'd1,  32'hFFFF_FF80};
        vecs[1] = '{3'b100, 32'h0000_1003, 32'h80FF_FF7F, 0, 5'd2,  32'h0000_0080};
        vecs[2] = '{3'b001, 32'h0000_2002, 32'h1234_5678, 3, 5'd3,  32'h0000_1234};
        vecs[3] = '{3'b101, 32'h0000_2000, 32'h1234_F678, 0, 5'd4,  32'h0000_F678};
        vecs[4] = '{3'b001, 32'h0000_2000, 32'h1234_F678, 1, 5'd5,  32'hFFFF_F678};
        vecs[5] = '{3'b010, 32'h0000_3004, 32'hDEAD_BEEF, 1, 5'd6,  32'hDEAD_BEEF};
        vecs[6] = '{3'b000, 32'h0000_0000, 32'h0000_00FF, 0, 5'd7,  32'hFFFF_FFFF};
        vecs[7] = '{3'b100, 32'h0000_0005, 32'h0000_AB00, 2, 5'd8,  32'h0000_00AB};
        vecs[8] = '{3'b011, 32'h0000_0008, 32'hCAFE_BABE, 0, 5'd31, 32'hCAFE_BABE};

        idle_inputs();
        fun3_i = 0; addr_i = 0; rd_i = 0;
        reset = 1;
        repeat (3) @(posedge clk);
        mid();
        chk("reset rd_req", {31'b0, rd_req_o}, 32'd0);
        chk("reset done", {31'b0, done_o}, 32'd0);
        chk("reset data", data_o, 32'd0);
        chk("reset stall", {31'b0, stall_o}, 32'd0);
        chk("reset rd_addr", rd_addr_o, 32'd0);
        tick();
        reset = 0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Misaligned LW: no bus request, no stall, fault pulse in cycle 1.
        tick(); issue(3'b010, 32'h0000_3001, 5'd9);
        mid();
        chk("mis stall_c0", {31'b0, stall_o}, 32'd0);
        tick(); idle_inputs(); mid();
        chk("mis pulse", {31'b0, load_misaligned_o}, 32'd1);
        chk("mis rd_req", {31'b0, rd_req_o}, 32'd0);
        chk("mis done", {31'b0, done_o}, 32'd0);
        chk("mis stall_c1", {31'b0, stall_o}, 32'd0);
        tick(); mid();
        chk("mis pulse_end", {31'b0, load_misaligned_o}, 32'd0);

        // Misaligned LH.
        tick(); issue(3'b101, 32'h0000_2001, 5'd9);
        tick(); idle_inputs(); mid();
        chk("mis_lh pulse", {31'b0, load_misaligned_o}, 32'd1);
        chk("mis_lh rd_req", {31'b0, rd_req_o}, 32'd0);

        // Bus error on first BUSY cycle.
        tick(); issue(3'b010, 32'h0000_7100, 5'd10);
        tick(); idle_inputs(); rd_ack_i = 1; rd_err_i = 1; rd_data_i = 32'h1111_1111;
        tick(); idle_inputs(); mid();
        chk("err fault", {31'b0, access_fault_o}, 32'd1);
        chk("err done", {31'b0, done_o}, 32'd0);
        chk("err data_kept", data_o, 32'hCAFE_BABE);
        chk("err rd_req", {31'b0, rd_req_o}, 32'd0);
        tick(); mid();
        chk("err fault_end", {31'b0, access_fault_o}, 32'd0);

        // Timeout after 4 BUSY cycles without ack.
        tick(); issue(3'b010, 32'h0000_7000, 5'd11);
        for (int c = 1; c <= 4; c++) begin
            tick(); idle_inputs(); mid();
            chk($sformatf("tmo rd_req_c%0d", c), {31'b0, rd_req_o}, 32'd1);
            chk($sformatf("tmo fault_c%0d", c), {31'b0, access_fault_o}, 32'd0);
        end
        tick(); mid();
        chk("tmo rd_req_drop", {31'b0, rd_req_o}, 32'd0);
        chk("tmo fault", {31'b0, access_fault_o}, 32'd1);
        chk("tmo done", {31'b0, done_o}, 32'd0);
        tick(); mid();
        chk("tmo fault_end", {31'b0, access_fault_o}, 32'd0);

        // Flush in BUSY cycle 1, ack in cycle 4: drained silently.
        tick(); issue(3'b010, 32'h0000_4000, 5'd12);
        tick(); idle_inputs(); flush_i = 1; mid();
        chk("fl rd_req_c1", {31'b0, rd_req_o}, 32'd1);
        for (int c = 2; c <= 4; c++) begin
            tick(); idle_inputs();
            if (c == 4) begin rd_ack_i = 1; rd_data_i = 32'h5555_AAAA; end
            mid();
            chk($sformatf("fl rd_req_c%0d", c), {31'b0, rd_req_o}, 32'd1);
            chk($sformatf("fl stall_c%0d", c), {31'b0, stall_o}, 32'd1);
        end
        tick(); idle_inputs(); mid();
        chk("fl rd_req_drop", {31'b0, rd_req_o}, 32'd0);
        chk("fl done", {31'b0, done_o}, 32'd0);
        chk("fl fault", {31'b0, access_fault_o}, 32'd0);
        chk("fl data_kept", data_o, 32'hCAFE_BABE);
        chk("fl stall", {31'b0, stall_o}, 32'd0);

        // Back-to-back LW accepted in DONE.
        tick(); issue(3'b010, 32'h0000_6000, 5'd3);
        tick(); idle_inputs(); rd_ack_i = 1; rd_data_i = 32'hA1A2_A3A4;
        tick(); issue(3'b010, 32'h0000_6004, 5'd4); mid();
        chk("b2b done1", {31'b0, done_o}, 32'd1);
        chk("b2b data1", data_o, 32'hA1A2_A3A4);
        chk("b2b rd1", {27'b0, rd_o}, 32'd3);
        chk("b2b stall_done", {31'b0, stall_o}, 32'd1);
        tick(); idle_inputs(); rd_ack_i = 1; rd_data_i = 32'hB1B2_B3B4; mid();
        chk("b2b rd_req2", {31'b0, rd_req_o}, 32'd1);
        chk("b2b rd_addr2", rd_addr_o, 32'h0000_6004);
        tick(); idle_inputs(); mid();
        chk("b2b done2", {31'b0, done_o}, 32'd1);
        chk("b2b data2", data_o, 32'hB1B2_B3B4);
        chk("b2b rd2", {27'b0, rd_o}, 32'd4);

        // Reset while BUSY.
        tick(); issue(3'b010, 32'h0000_5000, 5'd13);
        tick(); idle_inputs(); reset = 1; mid();
        chk("rst rd_req_before", {31'b0, rd_req_o}, 32'd1);
        tick(); reset = 0; mid();
        chk("rst rd_req", {31'b0, rd_req_o}, 32'd0);
        chk("rst rd_addr", rd_addr_o, 32'd0);
        chk("rst data", data_o, 32'd0);
        chk("rst rd", {27'b0, rd_o}, 32'd0);
        chk("rst done", {31'b0, done_o}, 32'd0);
        chk("rst stall", {31'b0, stall_o}, 32'd0);
        chk("rst fault", {31'b0, access_fault_o}, 32'd0);
        tick(); mid();
        chk("rst stays_idle", {31'b0, rd_req_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
